fifo_param: RTL and testbench

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_param.sv | 201 ++++++++++++++++++++
 tb/tb_fifo_param.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// fifo_param: synchronous FIFO with a parameterised depth, occupancy
// thresholds and sticky overflow/underflow flags.
//
// Build option: define FIFO_FWFT_EN to select first-word-fall-through.
// Left undefined, reads have one cycle of latency.
//
// Parameters
//   DATA_W    data width in bits
//   ADDR_W    pointer width; DEPTH = 2**ADDR_W entries
//   AFULL_TH  almost_full asserts while level >= AFULL_TH
//   AEMPTY_TH almost_empty asserts while level <= AEMPTY_TH
//
// Ports
//   clk          sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   we / wdata   write request and data
//   re           read request
//   flush        synchronous clear of contents (errors kept)
//   clr_err      synchronous clear of overflow/underflow
//   rdata        read data
//   fifo_empty, fifo_full, almost_empty, almost_full   status flags
//   level        occupancy, 0..DEPTH
//   overflow, underflow                               sticky error flags
//
// Request semantics: we and re are requests that the FIFO may refuse.
// A write is taken when we=1 and the FIFO is not full, or when a read is
// taken in the same cycle. A read is taken when re=1 and the FIFO is not
// empty. A refused write sets overflow; a refused read sets underflow.
// Nothing is taken while flush=1.
module fifo_param #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int AFULL_TH  = (1 << ADDR_W) - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic              flush,
    input  logic              clr_err,
    output logic [DATA_W-1:0] rdata,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_LVL = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   LVL_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic              empty_w, full_w;
    logic              rd_acc, wr_acc, mem_we;

`ifdef FIFO_FWFT_EN
    // Output stage: rdata_q holds the head word while out_valid_q is set.
    logic              out_valid_q, out_valid_d;
    logic              ram_nonempty;
    logic              bypass;
`endif

    always_comb begin
        empty_w = (level_q == '0);
        full_w  = (level_q == DEPTH_LVL);
        rd_acc  = !flush && re && !empty_w;
        // A read taken in the same cycle frees a slot, so a write at full still lands.
        wr_acc  = !flush && we && (!full_w || rd_acc);

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
`ifdef FIFO_FWFT_EN
        out_valid_d  = out_valid_q;
        bypass       = 1'b0;
        // Words held in the array = level minus the output-stage entry.
        ram_nonempty = out_valid_q ? (level_q > LVL_ONE) : (level_q != '0);
`endif

        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
`ifdef FIFO_FWFT_EN
            out_valid_d = 1'b0;
`endif
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
`ifdef FIFO_FWFT_EN
            // Refill the output stage when it is empty or being popped; when
            // the array has nothing queued, the incoming word goes straight in.
            if (!out_valid_q || rd_acc) begin
                if (ram_nonempty) begin
                    rdata_d     = mem_q[rptr_q];
                    rptr_d      = rptr_q + PTR_ONE;
                    out_valid_d = 1'b1;
                end else if (wr_acc) begin
                    rdata_d     = wdata;
                    bypass      = 1'b1;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            mem_we = wr_acc && !bypass;
`else
            mem_we = wr_acc;
            if (rd_acc) begin
                rdata_d = mem_q[rptr_q];
                rptr_d  = rptr_q + PTR_ONE;
            end
`endif
            if (mem_we) begin
                wptr_d = wptr_q + PTR_ONE;
            end
        end

        // A new error in the same cycle wins over clr_err.
        if (!flush && we && !wr_acc) begin
            ovf_d = 1'b1;
        end else if (clr_err) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        if (!flush && re && empty_w) begin
            udf_d = 1'b1;
        end else if (clr_err) begin
            udf_d = 1'b0;
        end else begin
            udf_d = udf_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            rdata_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            rdata_q <= rdata_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

`ifdef FIFO_FWFT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
        end
    end
`endif

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // All status is decoded from registered state only.
    assign rdata        = rdata_q;
    assign level        = level_q;
    assign fifo_empty   = (level_q == '0);
    assign fifo_full    = (level_q == DEPTH_LVL);
    assign almost_full  = (int'(level_q) >= AFULL_TH);
    assign almost_empty = (int'(level_q) <= AEMPTY_TH);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_param.sv
module tb_fifo_param;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 8;
    localparam int DEPTH     = 256;
    localparam int AFULL_TH  = 252;
    localparam int AEMPTY_TH = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic              we, re, flush, clr_err;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              fifo_empty, fifo_full, almost_full, almost_empty;
    logic [ADDR_W:0]   level;
    logic              overflow, underflow;

    fifo_param #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .AFULL_TH (AFULL_TH),
        .AEMPTY_TH(AEMPTY_TH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .we          (we),
        .wdata       (wdata),
        .re          (re),
        .flush       (flush),
        .clr_err     (clr_err),
        .rdata       (rdata),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    // ---------------- scoreboard / reference model ----------------
    int                total = 0;
    int                bad   = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] m_rdata;
    logic              m_ovf, m_udf;
    logic              m_last_wr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Occupancy-based reference: a queue holds the contents in order.
    task automatic model_step(input logic w, input logic [DATA_W-1:0] wd,
                              input logic r, input logic fl, input logic clr);
        int   n;
        logic rd, wr, so, su;
        n  = exp_q.size();
        rd = 1'b0;
        wr = 1'b0;
        so = 1'b0;
        su = 1'b0;
        if (fl) begin
            exp_q.delete();
        end else begin
            rd = r && (n > 0);
            wr = w && ((n < DEPTH) || rd);
            if (rd) m_rdata = exp_q.pop_front();
            if (wr) exp_q.push_back(wd);
            so = w && !wr;
            su = r && (n == 0);
        end
        m_last_wr = wr;
        if (so) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
        if (su) m_udf = 1'b1; else if (clr) m_udf = 1'b0;
    endtask

    task automatic check_all();
        int n;
        n = exp_q.size();
        check("level",        32'(level),        32'(n));
        check("fifo_empty",   32'(fifo_empty),   32'(n == 0));
        check("fifo_full",    32'(fifo_full),    32'(n == DEPTH));
        check("almost_full",  32'(almost_full),  32'(n >= AFULL_TH));
        check("almost_empty", 32'(almost_empty), 32'(n <= AEMPTY_TH));
        check("overflow",     32'(overflow),     32'(m_ovf));
        check("underflow",    32'(underflow),    32'(m_udf));
        check("rdata",        32'(rdata),        32'(m_rdata));
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: drive, take the rising edge, compare at the next falling edge.
    task automatic step(input logic w, input logic [DATA_W-1:0] wd,
                        input logic r, input logic fl, input logic clr);
        we      = w;
        wdata   = wd;
        re      = r;
        flush   = fl;
        clr_err = clr;
        @(posedge clk);
        model_step(w, wd, r, fl, clr);
        @(negedge clk);
        check_all();
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_rdata = '0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_level"},        32'(level),        32'd0);
        check({tag, "_empty"},        32'(fifo_empty),   32'd1);
        check({tag, "_full"},         32'(fifo_full),    32'd0);
        check({tag, "_almost_empty"}, 32'(almost_empty), 32'd1);
        check({tag, "_almost_full"},  32'(almost_full),  32'd0);
        check({tag, "_overflow"},     32'(overflow),     32'd0);
        check({tag, "_underflow"},    32'(underflow),    32'd0);
        check({tag, "_rdata"},        32'(rdata),        32'd0);
    endtask

    typedef struct {
        logic              w;
        logic [DATA_W-1:0] wd;
        logic              r;
        logic              fl;
        logic              clr;
        int                lvl;
        logic [DATA_W-1:0] rd;
        logic              udf;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int writes;
        int cyc;
        int wp;

        reset_n = 1'b0;
        we = 1'b0; re = 1'b0; flush = 1'b0; clr_err = 1'b0; wdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // ---------------- table-driven vectors ----------------
        //            we   wdata     re   fl   clr  lvl rdata     udf
        tbl[0]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 16'h0000, 1'b1};
        tbl[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 0, 16'h0000, 1'b0};
        tbl[2]  = '{1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 1, 16'h0000, 1'b0};
        tbl[3]  = '{1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 2, 16'h0000, 1'b0};
        tbl[4]  = '{1'b1, 16'h3333, 1'b1, 1'b0, 1'b0, 2, 16'h1111, 1'b0};
        tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1, 16'h2222, 1'b0};
        tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 16'h3333, 1'b0};
        tbl[7]  = '{1'b1, 16'h4444, 1'b1, 1'b0, 1'b0, 1, 16'h3333, 1'b1};
        tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0, 16'h4444, 1'b0};
        tbl[9]  = '{1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 1, 16'h4444, 1'b0};
        tbl[10] = '{1'b1, 16'h6666, 1'b1, 1'b1, 1'b0, 0, 16'h4444, 1'b0};
        tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 16'h4444, 1'b1};
        tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 0, 16'h4444, 1'b0};
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].w, tbl[i].wd, tbl[i].r, tbl[i].fl, tbl[i].clr);
            check($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            check($sformatf("tbl%0d_rdata", i), 32'(rdata), 32'(tbl[i].rd));
            check($sformatf("tbl%0d_underflow", i), 32'(underflow), 32'(tbl[i].udf));
        end

        // ---------------- fill to full ----------------
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, DATA_W'(i), 1'b0, 1'b0, 1'b0);
            if (i == AFULL_TH - 1) check("afull_below_th", 32'(almost_full), 32'd0);
            if (i == AFULL_TH)     check("afull_at_th",    32'(almost_full), 32'd1);
        end
        check("fill_full",  32'(fifo_full), 32'd1);
        check("fill_level", 32'(level),     32'd256);

        step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1);
        check("ovf_clr_vs_new_error", 32'(overflow), 32'd1);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Simultaneous read and write at full.
        step(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
        check("full_rw_level", 32'(level), 32'd256);
        check("full_rw_rdata", 32'(rdata), 32'h0001);

        // ---------------- drain ----------------
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        end
        check("drain_last_word", 32'(rdata),      32'hBEEF);
        check("drain_empty",     32'(fifo_empty), 32'd1);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        check("drain_underflow", 32'(underflow),  32'd1);
        check("drain_rdata_hold", 32'(rdata),     32'hBEEF);

        // ---------------- flush at level 10 ----------------
        for (int i = 0; i < 10; i++) begin
            step(1'b1, DATA_W'($urandom_range(16'hFFFF)), 1'b0, 1'b0, 1'b0);
        end
        check("pre_flush_level", 32'(level), 32'd10);
        step(1'b1, 16'h7777, 1'b1, 1'b1, 1'b0);
        check("flush_level", 32'(level),      32'd0);
        check("flush_empty", 32'(fifo_empty), 32'd1);
        check("flush_keeps_udf", 32'(underflow), 32'd1);

        // ---------------- reset in the middle of a write ----------------
        step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h5678, 1'b0, 1'b0, 1'b0);
        we    = 1'b1;
        wdata = 16'h9ABC;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("midreset");
        model_reset();
        @(negedge clk);
        we = 1'b0;
        reset_n = 1'b1;
        step(1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0);
        check("addr0_after_reset", 32'(dut.mem_q[0]), 32'hA5A5);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        check("first_word_after_reset", 32'(rdata), 32'hA5A5);

        // ---------------- random stream ----------------
        writes = 0;
        cyc    = 0;
        while (writes < 1000 && cyc < 20000) begin
            wp = ((cyc / 200) % 2 == 1) ? 70 : 40;
            step(($urandom_range(99) < wp), DATA_W'($urandom_range(16'hFFFF)),
                 ($urandom_range(99) < 55), 1'b0, ($urandom_range(31) == 0));
            if (m_last_wr) writes++;
            cyc++;
        end
        check("stream_word_count", 32'(writes), 32'd1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
